// File: rtl/binsearch_engine.sv
// Binary search over a sorted external synchronous-read memory.
// Parameters: DATA_WIDTH, ADDR_WIDTH, DEPTH (number of sorted entries),
//   MEM_LATENCY (read latency, 1..4 cycles).
// Ports:
//   clock, reset (async, active-high)
//   start/mode/key : search request, taken only while idle
//     mode 0 = exact match, mode 1 = lower bound
//   mem_rdata : read data from the memory
//   mem_addr/mem_rd : probe address and read strobe
//   busy/done/valid : handshake and status
//   found/result_idx : match flag and index (insertion point on a miss)
// Optional build macro BSEARCH_PROBE_CNT_EN adds output probe_cnt,
//   the number of probes used by the last search.
`timescale 1ns/1ps
module binsearch_engine #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 5,
  parameter int DEPTH       = 2**ADDR_WIDTH,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode,
  input  logic [DATA_WIDTH-1:0] key,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  output logic                  busy,
  output logic                  done,
  output logic                  valid,
  output logic                  found,
  output logic [ADDR_WIDTH:0]   result_idx
`ifdef BSEARCH_PROBE_CNT_EN
  ,
  output logic [$clog2(ADDR_WIDTH+2)-1:0] probe_cnt
`endif
);

  localparam int AW1 = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t state_q, state_n;

  logic [DATA_WIDTH-1:0] key_q, key_n;
  logic                  mode_q, mode_n;
  logic [AW1-1:0]        lo_q, lo_n;
  logic [AW1-1:0]        hi_q, hi_n;
  logic                  eq_q, eq_n;
  logic [ADDR_WIDTH-1:0] addr_q, addr_n;
  logic [1:0]            wcnt_q, wcnt_n;
  logic [AW1-1:0]        res_q, res_n;
  logic                  found_q, found_n;
  logic                  valid_q, valid_n;

  logic [ADDR_WIDTH-1:0] mid;
  logic [AW1-1:0]        probe;
  logic [AW1-1:0]        probe_p1;
  logic                  lt;
  logic                  hit;

  // Sum taken one bit wider so lo+hi never wraps.
  assign mid = ADDR_WIDTH'(({1'b0, lo_q} + {1'b0, hi_q}) >> 1);

  assign probe    = AW1'(addr_q);
  assign probe_p1 = AW1'(addr_q) + AW1'(1);
  assign lt       = mem_rdata < key_q;
  assign hit      = mem_rdata == key_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    key_n   = key_q;
    mode_n  = mode_q;
    lo_n    = lo_q;
    hi_n    = hi_q;
    eq_n    = eq_q;
    addr_n  = addr_q;
    wcnt_n  = wcnt_q;
    res_n   = res_q;
    found_n = found_q;
    valid_n = valid_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          key_n   = key;
          mode_n  = mode;
          lo_n    = '0;
          hi_n    = AW1'(DEPTH);
          eq_n    = 1'b0;
          valid_n = 1'b0;
          found_n = 1'b0;
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        addr_n = mid;
        wcnt_n = 2'(MEM_LATENCY - 2);
        if (MEM_LATENCY == 1) state_n = S_COMPARE;
        else                  state_n = S_WAIT;
      end
      S_WAIT: begin
        if (wcnt_q == 2'd0) state_n = S_COMPARE;
        else                wcnt_n  = wcnt_q - 2'd1;
      end
      S_COMPARE: begin
        if (lt) lo_n = probe_p1;
        else    hi_n = probe;
        if (hit) eq_n = 1'b1;
        if (!mode_q && hit) begin
          res_n   = probe;
          found_n = 1'b1;
          valid_n = 1'b1;
          state_n = S_DONE;
        end else if (lo_n < hi_n) begin
          state_n = S_ISSUE;
        end else begin
          // lo is the leftmost entry >= key
          res_n   = lo_n;
          found_n = eq_n;
          valid_n = 1'b1;
          state_n = S_DONE;
        end
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_q   <= '0;
      mode_q  <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      eq_q    <= 1'b0;
      addr_q  <= '0;
      wcnt_q  <= '0;
      res_q   <= '0;
      found_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      key_q   <= key_n;
      mode_q  <= mode_n;
      lo_q    <= lo_n;
      hi_q    <= hi_n;
      eq_q    <= eq_n;
      addr_q  <= addr_n;
      wcnt_q  <= wcnt_n;
      res_q   <= res_n;
      found_q <= found_n;
      valid_q <= valid_n;
    end
  end

  // Address is live in the issue cycle, then held for the memory.
  assign mem_addr   = (state_q == S_ISSUE) ? mid : addr_q;
  assign mem_rd     = (state_q == S_ISSUE);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign valid      = valid_q;
  assign found      = found_q;
  assign result_idx = res_q;

`ifdef BSEARCH_PROBE_CNT_EN
  logic [$clog2(ADDR_WIDTH+2)-1:0] pcnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      pcnt_q <= '0;
    else if (state_q == S_IDLE && start)
      pcnt_q <= '0;
    else if (state_q == S_COMPARE)
      pcnt_q <= pcnt_q + 1'b1;
  end

  assign probe_cnt = pcnt_q;
`endif

endmodule

// File: tb/tb_binsearch_engine.sv
// Directed bench for binsearch_engine: one instance at read latency 1,
// one at latency 3, both over the same behavioural memory.
`timescale 1ns/1ps
module tb_binsearch_engine;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       rst1, rst3, st1, st3, md1, md3;
  logic [7:0] k1, k3, rdat1, rdat3;
  logic [4:0] a1, a3;
  logic       rd1, rd3, busy1, busy3, dn1, dn3;
  logic       v1, v3, f1, f3;
  logic [5:0] ix1, ix3;
`ifdef BSEARCH_PROBE_CNT_EN
  logic [2:0] pc1, pc3;
`endif

  int nerr = 0;
  int nchk = 0;

  logic [7:0] mem [32];
  logic [7:0] junk = 8'h5a;
  logic [7:0] p1 = '0;
  logic       vp1 = 1'b0;
  logic [7:0] d3 [3];
  logic [2:0] vp3 = '0;

  binsearch_engine #(.MEM_LATENCY(1)) dut1 (
    .clock(clock), .reset(rst1), .start(st1), .mode(md1),
    .key(k1), .mem_rdata(rdat1), .mem_addr(a1), .mem_rd(rd1),
    .busy(busy1), .done(dn1), .valid(v1), .found(f1),
    .result_idx(ix1)
`ifdef BSEARCH_PROBE_CNT_EN
    , .probe_cnt(pc1)
`endif
  );

  binsearch_engine #(.MEM_LATENCY(3)) dut3 (
    .clock(clock), .reset(rst3), .start(st3), .mode(md3),
    .key(k3), .mem_rdata(rdat3), .mem_addr(a3), .mem_rd(rd3),
    .busy(busy3), .done(dn3), .valid(v3), .found(f3),
    .result_idx(ix3)
`ifdef BSEARCH_PROBE_CNT_EN
    , .probe_cnt(pc3)
`endif
  );

  // Memory model: data is real only in the cycle it is due,
  // random garbage otherwise.
  always @(posedge clock) begin
    junk  <= 8'($urandom);
    p1    <= mem[a1];
    vp1   <= rd1;
    d3[0] <= mem[a3];
    d3[1] <= d3[0];
    d3[2] <= d3[1];
    vp3   <= {vp3[1:0], rd3};
  end
  assign rdat1 = vp1 ? p1 : junk;
  assign rdat3 = vp3[2] ? d3[2] : junk;

  int np = 0;
  logic [4:0] plog [8];
  int ndone3 = 0;

  always @(negedge clock) begin
    if (rd1) begin
      if (np < 8) plog[np] = a1;
      np++;
    end
    if (dn3) ndone3++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Launch a search; inj>0 pulses a stray start (key 40) in that cycle.
  task automatic run(input bit u3, input logic m,
                     input logic [7:0] k, input int inj,
                     output int cyc);
    @(negedge clock);
    np = 0;
    if (u3) begin st3 = 1; md3 = m; k3 = k; end
    else    begin st1 = 1; md1 = m; k1 = k; end
    @(negedge clock);
    st1 = 0; st3 = 0;
    cyc = 1;
    while (!(u3 ? dn3 : dn1) && cyc < 100) begin
      if (cyc == inj) begin st1 = 1; k1 = 8'd40; end
      @(negedge clock);
      st1 = 0;
      cyc++;
    end
    chk(u3 ? "done3" : "done1", 32'(u3 ? dn3 : dn1), 1);
  endtask

  int c;

  initial begin
    rst1 = 1; rst3 = 1;
    st1 = 0; st3 = 0; md1 = 0; md3 = 0; k1 = 0; k3 = 0;
    for (int i = 0; i < 32; i++) mem[i] = 8'(2 * i);
    @(negedge clock);
    @(negedge clock);
    chk("rst1", 32'({a1, rd1, busy1, dn1, v1, f1, ix1}), 0);
    chk("rst3", 32'({a3, rd3, busy3, dn3, v3, f3, ix3}), 0);
    rst1 = 0; rst3 = 0;
    @(negedge clock);
    chk("idle_busy", 32'({busy1, busy3, v1, v3}), 0);

    run(0, 0, 8'd12, 0, c);
    chk("k12_found", 32'(f1), 1);
    chk("k12_idx", 32'(ix1), 6);
    chk("k12_cyc", 32'(c), 9);
    chk("k12_valid", 32'(v1), 1);
    chk("k12_nprobe", 32'(np), 4);
    chk("k12_mids", 32'({plog[0], plog[1], plog[2], plog[3]}),
        32'({5'd16, 5'd8, 5'd4, 5'd6}));
`ifdef BSEARCH_PROBE_CNT_EN
    chk("k12_pcnt", 32'(pc1), 4);
`endif
    @(negedge clock);
    chk("k12_after", 32'({busy1, dn1, v1, f1}), 32'b0011);
    chk("k12_hold", 32'(ix1), 6);

    run(0, 0, 8'd13, 0, c);
    chk("k13_found", 32'(f1), 0);
    chk("k13_idx", 32'(ix1), 7);
    chk("k13_cyc", 32'(c), 11);
`ifdef BSEARCH_PROBE_CNT_EN
    chk("k13_pcnt", 32'(pc1), 5);
`endif

    run(0, 0, 8'd63, 0, c);
    chk("k63_found", 32'(f1), 0);
    chk("k63_idx", 32'(ix1), 32);

    run(0, 0, 8'd0, 0, c);
    chk("k0_found", 32'(f1), 1);
    chk("k0_idx", 32'(ix1), 0);
    chk("k0_cyc", 32'(c), 13);

    run(0, 1, 8'd12, 0, c);
    chk("lb12_found", 32'(f1), 1);
    chk("lb12_idx", 32'(ix1), 6);
    chk("lb12_cyc", 32'(c), 11);

    run(1, 0, 8'd12, 0, c);
    chk("l3_found", 32'(f3), 1);
    chk("l3_idx", 32'(ix3), 6);
    chk("l3_cyc", 32'(c), 17);

    run(0, 0, 8'd12, 3, c);
    chk("inj_found", 32'(f1), 1);
    chk("inj_idx", 32'(ix1), 6);
    chk("inj_cyc", 32'(c), 9);
    @(negedge clock);
    @(negedge clock);
    chk("inj_noqueue", 32'(busy1), 0);

    // Abort a latency-3 search while it waits on memory.
    @(negedge clock);
    st3 = 1; md3 = 0; k3 = 8'd12;
    @(negedge clock);
    st3 = 0;
    @(negedge clock);
    ndone3 = 0;
    rst3 = 1;
    @(posedge clock);
    #1;
    chk("abort_out", 32'({a3, rd3, busy3, dn3, v3, f3, ix3}), 0);
    @(negedge clock);
    rst3 = 0;
    repeat (20) @(negedge clock);
    chk("abort_nodone", 32'(ndone3), 0);
    chk("abort_idle", 32'(busy3), 0);
    run(1, 0, 8'd13, 0, c);
    chk("post_found", 32'(f3), 0);
    chk("post_idx", 32'(ix3), 7);
    chk("post_cyc", 32'(c), 21);

    // Duplicates: mem[4..9] = 10.
    for (int i = 0; i < 32; i++)
      mem[i] = (i >= 4 && i <= 9) ? 8'd10 : 8'(2 * i);
    run(0, 1, 8'd10, 0, c);
    chk("dup_lb_found", 32'(f1), 1);
    chk("dup_lb_idx", 32'(ix1), 4);
    run(0, 0, 8'd10, 0, c);
    chk("dup_ex_found", 32'(f1), 1);
    chk("dup_ex_range", 32'(ix1 >= 6'd4 && ix1 <= 6'd9), 1);
    run(0, 1, 8'd11, 0, c);
    chk("dup_ins_found", 32'(f1), 0);
    chk("dup_ins_idx", 32'(ix1), 10);
    run(1, 1, 8'd10, 0, c);
    chk("dup3_found", 32'(f3), 1);
    chk("dup3_idx", 32'(ix3), 4);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
